// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs bytes big-endian into 512-bit blocks, appends 0x80/zeros/bit-length, and sequences core_init/core_next.
// Optional build macro SHA256_PADDER_BLKCNT_EN adds the blk_count output (per-message block command count).
module sha256_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  input  logic         data_last,
  output logic         data_ready,
  input  logic         msg_empty,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [255:0] core_digest,
  output logic [255:0] hash,
  output logic         hash_valid
`ifdef SHA256_PADDER_BLKCNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  localparam int unsigned BLK_W    = 512;
  localparam int unsigned DIG_W    = 256;
  localparam int unsigned LEN_W    = 64;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned BYTES    = 64;
  localparam int unsigned LEN_ROOM = 55;  // last byte index that still leaves room for the length field
  localparam int unsigned BC_W     = 32;

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, ARM, WAIT, PAD, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [BLK_W-1:0]   r_blk, w_blk_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic               r_init_sent, w_init_sent_nxt;
  logic               r_pend, w_pend_nxt;
  logic               r_pend_mark, w_pend_mark_nxt;
  logic               r_final, w_final_nxt;
  logic [DIG_W-1:0]   r_hash, w_hash_nxt;
  logic               r_hash_valid, w_hash_valid_nxt;
  logic               r_core_init, w_core_init_nxt;
  logic               r_core_next, w_core_next_nxt;
  logic               r_data_ready, w_data_ready_nxt;
  logic               w_accept;
  logic [8:0]         w_byte_pos;
`ifdef SHA256_PADDER_BLKCNT_EN
  logic [BC_W-1:0]    r_blk_count, w_blk_count_nxt;
`endif

  assign w_accept   = data_valid & r_data_ready;
  assign w_byte_pos = 9'd511 - {r_cnt[5:0], 3'b000};

  // Next-state, datapath and command generation
  always_comb begin
    w_state_nxt      = r_state;
    w_blk_nxt        = r_blk;
    w_cnt_nxt        = r_cnt;
    w_len_nxt        = r_len;
    w_init_sent_nxt  = r_init_sent;
    w_pend_nxt       = r_pend;
    w_pend_mark_nxt  = r_pend_mark;
    w_final_nxt      = r_final;
    w_hash_nxt       = r_hash;
    w_hash_valid_nxt = r_hash_valid;
    w_core_init_nxt  = 1'b0;
    w_core_next_nxt  = 1'b0;
    w_data_ready_nxt = 1'b0;
`ifdef SHA256_PADDER_BLKCNT_EN
    w_blk_count_nxt  = r_blk_count;
`endif

    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_blk_nxt[BLK_W-1 -: 8] = data_in;
          w_cnt_nxt        = CNT_W'(1);
          w_len_nxt        = LEN_W'(8);
          w_init_sent_nxt  = 1'b0;
          w_pend_nxt       = 1'b0;
          w_pend_mark_nxt  = 1'b0;
          w_hash_valid_nxt = 1'b0;
          w_state_nxt      = data_last ? PAD : FILL;
        end else if (msg_empty) begin
          w_cnt_nxt        = '0;
          w_len_nxt        = '0;
          w_init_sent_nxt  = 1'b0;
          w_pend_nxt       = 1'b0;
          w_pend_mark_nxt  = 1'b0;
          w_hash_valid_nxt = 1'b0;
          w_state_nxt      = PAD;
        end
      end

      FILL: begin
        if (w_accept) begin
          w_blk_nxt[w_byte_pos -: 8] = data_in;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_len_nxt = r_len + LEN_W'(8);
          if (r_cnt == CNT_W'(BYTES - 1)) begin
            // Full block; a last byte here leaves a pad-only block pending
            w_final_nxt     = 1'b0;
            w_pend_nxt      = data_last;
            w_pend_mark_nxt = data_last;
            w_state_nxt     = ISSUE;
          end else if (data_last) begin
            w_state_nxt = PAD;
          end
        end
      end

      PAD: begin
        if (r_pend) begin
          w_blk_nxt                = '0;
          w_blk_nxt[BLK_W-1 -: 8]  = r_pend_mark ? 8'h80 : 8'h00;
          w_blk_nxt[LEN_W-1:0]     = r_len;
          w_final_nxt              = 1'b1;
          w_pend_nxt               = 1'b0;
          w_pend_mark_nxt          = 1'b0;
        end else begin
          for (int i = 0; i < BYTES; i++) begin
            if (CNT_W'(i) == r_cnt) begin
              w_blk_nxt[9'(BLK_W - 1 - 8 * i) -: 8] = 8'h80;
            end else if (CNT_W'(i) > r_cnt) begin
              w_blk_nxt[9'(BLK_W - 1 - 8 * i) -: 8] = 8'h00;
            end
          end
          if (r_cnt <= CNT_W'(LEN_ROOM)) begin
            w_blk_nxt[LEN_W-1:0] = r_len;
            w_final_nxt          = 1'b1;
          end else begin
            w_final_nxt     = 1'b0;
            w_pend_nxt      = 1'b1;
            w_pend_mark_nxt = 1'b0;
          end
        end
        w_state_nxt = ISSUE;
      end

      ISSUE: begin
        w_init_sent_nxt = 1'b1;
        w_state_nxt     = ARM;
      end

      ARM: w_state_nxt = WAIT;

      WAIT: begin
        if (core_ready) begin
          if (r_final) begin
            w_hash_nxt       = core_digest;
            w_hash_valid_nxt = 1'b1;
            w_state_nxt      = DONE;
          end else if (r_pend) begin
            w_state_nxt = PAD;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = FILL;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    if (w_state_nxt == ISSUE) begin
      w_core_init_nxt = ~r_init_sent;
      w_core_next_nxt = r_init_sent;
`ifdef SHA256_PADDER_BLKCNT_EN
      w_blk_count_nxt = r_init_sent ? r_blk_count + BC_W'(1) : BC_W'(1);
`endif
    end

    w_data_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == DONE) ||
                       ((w_state_nxt == FILL) && (w_cnt_nxt < CNT_W'(BYTES)));
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_blk        <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_init_sent  <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_mark  <= 1'b0;
      r_final      <= 1'b0;
      r_hash       <= '0;
      r_hash_valid <= 1'b0;
      r_core_init  <= 1'b0;
      r_core_next  <= 1'b0;
      r_data_ready <= 1'b1;
`ifdef SHA256_PADDER_BLKCNT_EN
      r_blk_count  <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_blk        <= w_blk_nxt;
      r_cnt        <= w_cnt_nxt;
      r_len        <= w_len_nxt;
      r_init_sent  <= w_init_sent_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_mark  <= w_pend_mark_nxt;
      r_final      <= w_final_nxt;
      r_hash       <= w_hash_nxt;
      r_hash_valid <= w_hash_valid_nxt;
      r_core_init  <= w_core_init_nxt;
      r_core_next  <= w_core_next_nxt;
      r_data_ready <= w_data_ready_nxt;
`ifdef SHA256_PADDER_BLKCNT_EN
      r_blk_count  <= w_blk_count_nxt;
`endif
    end
  end

  assign data_ready = r_data_ready;
  assign core_init  = r_core_init;
  assign core_next  = r_core_next;
  assign core_block = r_blk;
  assign hash       = r_hash;
  assign hash_valid = r_hash_valid;
`ifdef SHA256_PADDER_BLKCNT_EN
  assign blk_count  = r_blk_count;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: behavioural SHA-256 core plus standard-padding reference model.
// Build with SHA256_PADDER_BLKCNT_EN defined to also check blk_count.
module tb_sha256_padder;

  typedef logic [7:0]   byte_q_t [$];
  typedef logic [511:0] blk_q_t  [$];

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] KAT_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] KAT_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] KAT_M56   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK   = {8'h61, 8'h62, 8'h63, 8'h80, 416'h0, 64'h18};
  localparam logic [511:0] PAD64_BLK = {8'h80, 440'h0, 64'h200};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk, reset;
  logic [7:0]   data_in;
  logic         data_valid, data_last, data_ready, msg_empty;
  logic         core_init, core_next, core_ready;
  logic [511:0] core_block;
  logic [255:0] core_digest, hash;
  logic         hash_valid;
`ifdef SHA256_PADDER_BLKCNT_EN
  logic [31:0]  blk_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sha256_padder dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .msg_empty(msg_empty), .core_init(core_init), .core_next(core_next),
    .core_block(core_block), .core_ready(core_ready), .core_digest(core_digest),
    .hash(hash), .hash_valid(hash_valid)
`ifdef SHA256_PADDER_BLKCNT_EN
    , .blk_count(blk_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    logic [511:0] tmp;
    for (int i = 0; i < 16; i++) begin
      tmp  = blk << (32 * i);
      w[i] = tmp[511:480];
    end
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Standard SHA-256 padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length
  function automatic blk_q_t ref_pad(input byte_q_t m);
    byte_q_t      p;
    blk_q_t       out;
    logic [63:0]  bits;
    logic [511:0] blk;
    p    = m;
    bits = 64'(m.size()) << 3;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    for (int k = 0; k < p.size(); k += 64) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk = {blk[503:0], p[k + j]};
      out.push_back(blk);
    end
    return out;
  endfunction

  function automatic byte_q_t str_bytes(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    return q;
  endfunction

  // Behavioural SHA-256 core: records every command, keeps ready stale through ARM
  logic [255:0] m_state;
  logic [511:0] m_hold;
  int           m_phase, m_lat, cmd_total;
  bit           m_busy, m_prev_cmd, hold_ready;
  blk_q_t       rec_blk;
  bit           rec_init [$];

  initial begin
    core_ready = 1'b1; core_digest = '0; m_state = '0; m_hold = '0;
    m_phase = 0; m_lat = 0; cmd_total = 0; m_busy = 0; m_prev_cmd = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 0; m_phase = 0; m_prev_cmd = 0; core_ready = 1'b1;
      end else if (core_init || core_next) begin
        check("cmd_both", 512'(core_init & core_next), 512'(0));
        check("cmd_1cyc", 512'(m_prev_cmd), 512'(0));
        m_state     = sha_compress(core_init ? IV : m_state, core_block);
        core_digest = m_state;
        rec_blk.push_back(core_block);
        rec_init.push_back(core_init);
        cmd_total++;
        m_hold = core_block; m_busy = 1; m_phase = 1; m_lat = $urandom_range(0, 4); m_prev_cmd = 1;
      end else begin
        m_prev_cmd = 0;
        if (m_busy) begin
          check("blk_hold", core_block, m_hold);
          if (m_phase == 1) m_phase = 2;
          else if (m_phase == 2) begin core_ready = 1'b0; m_phase = 3; end
          else if (!hold_ready) begin
            if (m_lat > 0) m_lat--;
            else begin core_ready = 1'b1; m_busy = 0; m_phase = 0; end
          end
        end
      end
    end
  end

  task automatic check_reset_state();
    check("rst_init",  512'(core_init), 512'(0));
    check("rst_next",  512'(core_next), 512'(0));
    check("rst_block", core_block, 512'(0));
    check("rst_hash",  512'(hash), 512'(0));
    check("rst_hv",    512'(hash_valid), 512'(0));
    check("rst_ready", 512'(data_ready), 512'(1));
`ifdef SHA256_PADDER_BLKCNT_EN
    check("rst_bcnt",  512'(blk_count), 512'(0));
`endif
  endtask

  // Called on a negedge; returns on the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps, input bit noise);
    int t = 0;
    int g = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (g) begin
      msg_empty = noise && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      msg_empty = 1'b0;
    end
    data_valid = 1'b1; data_in = b; data_last = last;
    while (!data_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("ready_timeout", 512'(0), 512'(1));
    @(negedge clk);
    data_valid = 1'b0; data_last = 1'b0; msg_empty = 1'b0;
  endtask

  task automatic run_msg(input byte_q_t msg, input bit via_empty, input bit with_first,
                         input bit gaps, input bit has_kat, input logic [255:0] kat);
    blk_q_t       exp;
    logic [255:0] hm;
    int           t = 0;
    rec_blk.delete(); rec_init.delete();
    exp = ref_pad(msg);
    hm  = IV;
    foreach (exp[i]) hm = sha_compress(hm, exp[i]);
    if (via_empty) begin
      msg_empty = 1'b1;
      @(negedge clk);
      msg_empty = 1'b0;
      check("hv_clear", 512'(hash_valid), 512'(0));
    end else begin
      for (int i = 0; i < msg.size(); i++) begin
        if (i == 0) msg_empty = with_first;
        send_byte(msg[i], i == msg.size() - 1, gaps, i > 0);
        if (i == 0) check("hv_clear", 512'(hash_valid), 512'(0));
      end
    end
    while (!hash_valid && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) check("hash_timeout", 512'(0), 512'(1));
    check("nblk", 512'(rec_blk.size()), 512'(exp.size()));
    for (int i = 0; i < exp.size() && i < rec_blk.size(); i++) begin
      check("blk", rec_blk[i], exp[i]);
      check("cmd_kind", 512'(rec_init[i]), 512'(i == 0));
    end
    check("hash", 512'(hash), 512'(hm));
    if (has_kat) check("hash_kat", 512'(hash), 512'(kat));
`ifdef SHA256_PADDER_BLKCNT_EN
    check("blk_count", 512'(blk_count), 512'(exp.size()));
`endif
    repeat (3) @(negedge clk);
    check("hv_hold", 512'(hash_valid), 512'(1));
    check("hash_hold", 512'(hash), 512'(hm));
    check("done_ready", 512'(data_ready), 512'(1));
  endtask

  initial begin
    byte_q_t m;
    int      lens [12] = '{1, 55, 56, 57, 63, 64, 65, 119, 120, 128, 129, 200};
    int      c0, t;
    reset = 1'b1; data_in = '0; data_valid = 1'b0; data_last = 1'b0; msg_empty = 1'b0; hold_ready = 0;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 512'(data_ready), 512'(1));

    run_msg(m, 1'b1, 1'b0, 1'b0, 1'b1, KAT_EMPTY);

    run_msg(str_bytes("abc"), 1'b0, 1'b0, 1'b0, 1'b1, KAT_ABC);
    check("abc_block", rec_blk[0], ABC_BLK);

    run_msg(str_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0, 1'b0, 1'b1, 1'b1, KAT_M56);
    check("m56_len", 512'(rec_blk[1][63:0]), 512'h1c0);

    m.delete();
    repeat (64) m.push_back(8'h61);
    run_msg(m, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("a64_padonly", rec_blk[1], PAD64_BLK);

    // msg_empty together with the first byte: the byte wins
    run_msg(str_bytes("abc"), 1'b0, 1'b1, 1'b0, 1'b1, KAT_ABC);

    for (int r = 0; r < 16; r++) begin
      int len = (r < 12) ? lens[r] : int'($urandom_range(0, 150));
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      run_msg(m, len == 0, 1'b0, 1'b1, 1'b0, '0);
    end

    // Reset while the core is busy on the first block
    hold_ready = 1;
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0, 1'b1, i > 0);
    t = 0;
    while (m_phase != 3 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("wait_timeout", 512'(0), 512'(1));
    repeat (3) @(negedge clk);
    c0 = cmd_total;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; hold_ready = 0;
    @(negedge clk);
    check_reset_state();
    repeat (20) @(negedge clk);
    check("no_cmd_after_rst", 512'(cmd_total), 512'(c0));
    run_msg(str_bytes("abc"), 1'b0, 1'b0, 1'b1, 1'b1, KAT_ABC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports data_in (input, 8 bits) and data_valid (input, 1 bit): the message byte and its qualifier.
REQ-004 SHALL have port data_last, input, 1 bit: marks the final byte of a message.
REQ-005 SHALL have port data_ready, output, 1 bit: a byte is accepted when data_valid and data_ready are both 1.
REQ-006 SHALL have port msg_empty, input, 1 bit: a one-cycle pulse in IDLE that hashes the zero-length message.
REQ-007 SHALL have ports core_init (output, 1 bit) and core_next (output, 1 bit): one-cycle command pulses to the SHA-256 core.
REQ-008 SHALL have port core_block, output, 512 bits: the padded block presented to the core.
REQ-009 SHALL have ports core_ready (input, 1 bit) and core_digest (input, 256 bits): driven by the SHA-256 core.
REQ-010 SHALL have ports hash (output, 256 bits) and hash_valid (output, 1 bit): the final message digest and its flag.

Function
REQ-011 SHALL use states IDLE, FILL, ISSUE, ARM, WAIT, PAD and DONE.
REQ-012 Byte order SHALL be big-endian: message byte i of a block lands in core_block[511-8i -: 8].
REQ-013 data_ready SHALL be 1 only in IDLE, in FILL with fewer than 64 buffered bytes, and in DONE.
REQ-014 Byte accepted in IDLE or DONE SHALL clear hash_valid, the 64-bit bit-length counter and the first-block flag, and enter FILL.
REQ-015 Each accepted byte SHALL add 8 to the length counter, which wraps modulo 2^64.
REQ-016 Accepting the 64th byte of a block SHALL enter ISSUE.
REQ-017 Accepting data_last with n<64 bytes buffered SHALL go to PAD; with n=64 it SHALL go to ISSUE and then schedule a pad-only block.
REQ-018 PAD, with n bytes buffered: byte n = 0x80, remaining bytes zero.
REQ-019 PAD with n<=55: core_block[63:0] = length counter, and this is the final block.
REQ-020 PAD with 56<=n<=63: issue the block with no length field, then a second block of all zeros with core_block[63:0] = length.
REQ-021 PAD with n=64 (pad-only block): byte 0 = 0x80, all other bytes zero, core_block[63:0] = length.
REQ-022 ISSUE SHALL last exactly one cycle: core_init=1 on the first block of a message, core_next=1 otherwise, never both.
REQ-023 core_block SHALL be held stable from ISSUE until WAIT exits.
REQ-024 ARM SHALL last one cycle with core_ready ignored; WAIT SHALL hold until core_ready=1.
REQ-025 On leaving WAIT: more data goes to FILL, a pending pad block goes to PAD, and after the final block hash <= core_digest, hash_valid <= 1, state DONE.
REQ-026 msg_empty in IDLE or DONE SHALL issue one block of 0x80 followed by zeros, with length 0.
REQ-027 In DONE, hash and hash_valid SHALL hold until the next message starts.
REQ-028 Simultaneous msg_empty and data_valid SHALL let data_valid win; msg_empty outside IDLE/DONE SHALL be ignored.

Reset
REQ-029 Reset SHALL force IDLE, with core_init=0, core_next=0, core_block=0, hash=0, hash_valid=0, data_ready=1, counters=0.
REQ-030 Reset mid-message SHALL abandon the message with no further core commands; the next message starts with core_init.

Configuration
REQ-031 With SHA256_PADDER_BLKCNT_EN defined, output blk_count (32 bits) SHALL count the core_init/core_next pulses of the current message.
REQ-032 With SHA256_PADDER_BLKCNT_EN defined, blk_count SHALL be reset to 0 by reset, set to 1 on core_init, and wrap modulo 2^32.
REQ-033 Without SHA256_PADDER_BLKCNT_EN, the blk_count port and its logic SHALL be absent, with no other behavioural change.

Verification
REQ-034 msg_empty pulse -> one core_init -> hash=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-035 "abc" (data_last on 0x63) -> core_block=61626380..0018, one core_init -> hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-036 56-byte "abcdbcde...nopq" -> core_init then core_next, second block length 0x1C0 -> hash=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-037 64 bytes of 0x61 -> full block, then pad-only block 0x80..0200 -> matches the reference SHA-256 of 64 'a' characters.
REQ-038 Random data_valid gaps plus reset asserted in WAIT -> no commands after reset; a following "abc" still yields ba7816bf...; blk_count=1 when SHA256_PADDER_BLKCNT_EN is defined.
